// File: rtl/scan_mux_pkg.sv
// Shared types and helpers for the scan_mux channel selector.
package scan_mux_pkg;

    // Controller states: direct host select, autonomous scan, scan with no enabled channel
    typedef enum logic [1:0] {
        MANUAL = 2'd0,
        SCAN   = 2'd1,
        NOCH   = 2'd2
    } state_t;

    // Encoding of the mode input
    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Largest supported channel count and the matching index width
    localparam int MAX_CH    = 64;
    localparam int MAX_SEL_W = 6;

    // Rotate-and-priority-encode: first set bit of mask at or after start,
    // searching upward and wrapping at n_ch-1 -> 0. Returns start when no
    // bit is set. Callers wanting "strictly after" pass start = sel+1.
    function automatic logic [MAX_SEL_W-1:0] next_en(
        input logic [MAX_SEL_W-1:0] start,
        input logic [MAX_CH-1:0]    mask,
        input int                   n_ch
    );
        logic [MAX_SEL_W:0] j;
        logic               found;
        next_en = start;
        found   = 1'b0;
        for (int k = 0; k < MAX_CH; k++) begin
            j = {1'b0, start} + 7'(k);
            if (j >= 7'(n_ch)) begin
                j = j - 7'(n_ch);
            end
            if (!found && (k < n_ch) && mask[j[MAX_SEL_W-1:0]]) begin
                next_en = j[MAX_SEL_W-1:0];
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/scan_mux_rr_next_sel.sv
// Combinational wrap-around finder: next enabled channel at or after i_start.
module rr_next_sel #(
    parameter int N_CH  = 4,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic [SEL_W-1:0] i_start,
    input  logic [N_CH-1:0]  i_mask,
    output logic [SEL_W-1:0] o_next
);
    import scan_mux_pkg::*;

    logic [MAX_SEL_W-1:0] w_start_ext;
    logic [MAX_CH-1:0]    w_mask_ext;
    logic [MAX_SEL_W-1:0] w_found;

    // Widen to the package's fixed search width, search, then narrow back
    assign w_start_ext = MAX_SEL_W'(i_start);
    assign w_mask_ext  = MAX_CH'(i_mask);
    assign w_found     = next_en(w_start_ext, w_mask_ext, N_CH);
    assign o_next      = SEL_W'(w_found);

endmodule

// File: rtl/scan_mux.sv
// Registered N:1 channel multiplexer with manual select or autonomous
// dwell-timed scanning of enabled channels, valid/ready on the output.
module scan_mux #(
    parameter  int N_CH    = 4,
    parameter  int WIDTH   = 1,
    parameter  int DWELL_W = 8,
    localparam int SEL_W   = $clog2(N_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel_in,
    input  logic                    sel_load,
    input  logic [DWELL_W-1:0]      dwell,
    input  logic [N_CH-1:0]         chan_en,
    input  logic [N_CH*WIDTH-1:0]   d,
    output logic [WIDTH-1:0]        y,
    output logic [SEL_W-1:0]        y_sel,
    output logic                    y_valid,
    input  logic                    y_ready
);
    import scan_mux_pkg::*;

    if (N_CH < 2 || N_CH > MAX_CH) begin : g_bad_n_ch
        $error("scan_mux: N_CH must be in 2..64");
    end

    // Channel count in a width that can be compared against sel_in directly
    localparam logic [SEL_W:0] N_CH_V = (SEL_W+1)'(N_CH);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [SEL_W-1:0]     r_sel;
    logic [SEL_W-1:0]     w_sel_nxt;
    logic [DWELL_W-1:0]   r_cnt;
    logic [DWELL_W-1:0]   w_cnt_nxt;
    logic [WIDTH-1:0]     r_y;
    logic [WIDTH-1:0]     w_y_nxt;
    logic [SEL_W-1:0]     r_y_sel;
    logic [SEL_W-1:0]     w_y_sel_nxt;
    logic                 r_y_valid;
    logic                 w_y_valid_nxt;

    logic                 w_load_ok;
    logic                 w_cap_ok;
    logic                 w_sel_en;
    logic                 w_any_en;
    logic                 w_dwell_done;
    logic [WIDTH-1:0]     w_d_sel;
    logic [SEL_W-1:0]     w_sel_inc;
    logic [SEL_W-1:0]     w_rr_start;
    logic [SEL_W-1:0]     w_rr_next;

    // Out-of-range select values are dropped rather than aliased
    assign w_load_ok    = sel_load && ({1'b0, sel_in} < N_CH_V);
    // A new sample may only replace y once the old one is gone or leaving
    assign w_cap_ok     = !r_y_valid || y_ready;
    assign w_sel_en     = chan_en[r_sel];
    assign w_any_en     = |chan_en;
    // >= so a dwell lowered below the running count still triggers a compare
    assign w_dwell_done = (r_cnt >= dwell);
    assign w_d_sel      = d[int'(r_sel)*WIDTH +: WIDTH];
    assign w_sel_inc    = (r_sel == SEL_W'(N_CH-1)) ? '0 : r_sel + 1'b1;

    // Scan advance searches strictly after sel; leaving NOCH searches from sel itself
    assign w_rr_start = (r_state == NOCH) ? r_sel : w_sel_inc;

    rr_next_sel #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_rr_next_sel (
        .i_start (w_rr_start),
        .i_mask  (chan_en),
        .o_next  (w_rr_next)
    );

    // Next-state, counter, select and output sample decisions
    always_comb begin
        w_state_nxt   = r_state;
        w_sel_nxt     = w_load_ok ? sel_in : r_sel;
        w_cnt_nxt     = r_cnt;
        w_y_nxt       = r_y;
        w_y_sel_nxt   = r_y_sel;
        w_y_valid_nxt = r_y_valid && !y_ready;

        if (mode == MODE_MANUAL) begin
            // Manual tracking applies from the switching edge; pending scan samples are dropped
            w_state_nxt   = MANUAL;
            w_cnt_nxt     = '0;
            w_y_nxt       = w_d_sel;
            w_y_sel_nxt   = r_sel;
            w_y_valid_nxt = w_sel_en;
        end else begin
            unique case (r_state)
                MANUAL: begin
                    w_state_nxt   = SCAN;
                    w_cnt_nxt     = '0;
                    w_y_valid_nxt = 1'b0;
                end
                SCAN: begin
                    if (!w_any_en) begin
                        w_state_nxt = NOCH;
                        w_cnt_nxt   = '0;
                    end else if (w_load_ok) begin
                        // A host load restarts the dwell and pre-empts any capture
                        w_cnt_nxt = '0;
                    end else if (!w_dwell_done) begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end else if (w_cap_ok) begin
                        w_cnt_nxt = '0;
                        w_sel_nxt = w_rr_next;
                        if (w_sel_en) begin
                            w_y_nxt       = w_d_sel;
                            w_y_sel_nxt   = r_sel;
                            w_y_valid_nxt = 1'b1;
                        end
                    end
                end
                NOCH: begin
                    w_cnt_nxt = '0;
                    if (w_any_en) begin
                        w_state_nxt = SCAN;
                        if (!w_load_ok) begin
                            w_sel_nxt = w_rr_next;
                        end
                    end
                end
                default: begin
                    w_state_nxt = MANUAL;
                end
            endcase
        end
    end

    // Control state register: FSM state, select and dwell counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= MANUAL;
            r_sel   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Output sample register; reset discards any pending sample
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_y       <= '0;
            r_y_sel   <= '0;
            r_y_valid <= 1'b0;
        end else begin
            r_y       <= w_y_nxt;
            r_y_sel   <= w_y_sel_nxt;
            r_y_valid <= w_y_valid_nxt;
        end
    end

    assign y       = r_y;
    assign y_sel   = r_y_sel;
    assign y_valid = r_y_valid;

endmodule

// File: tb/tb_scan_mux.sv
// Directed bench for scan_mux (N_CH=6, WIDTH=4) with an output scoreboard.
module tb_scan_mux;
    localparam int N_CH    = 6;
    localparam int WIDTH   = 4;
    localparam int DWELL_W = 8;
    localparam int SEL_W   = 3;

    // Channel data patterns: ch0 in the low nibble
    localparam logic [23:0] D_A = 24'h654321;
    localparam logic [23:0] D_B = 24'h9ABCDE;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  mode;
    logic [SEL_W-1:0]      sel_in;
    logic                  sel_load;
    logic [DWELL_W-1:0]    dwell;
    logic [N_CH-1:0]       chan_en;
    logic [N_CH*WIDTH-1:0] d;
    logic [WIDTH-1:0]      y;
    logic [SEL_W-1:0]      y_sel;
    logic                  y_valid;
    logic                  y_ready;

    int          checks = 0;
    int          errors = 0;
    bit          mon_on = 1'b0;
    logic [6:0]  exp_q[$];
    logic [6:0]  mon_exp;
    int          msel;

    always #5 clk = ~clk;

    scan_mux #(
        .N_CH    (N_CH),
        .WIDTH   (WIDTH),
        .DWELL_W (DWELL_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .sel_in   (sel_in),
        .sel_load (sel_load),
        .dwell    (dwell),
        .chan_en  (chan_en),
        .d        (d),
        .y        (y),
        .y_sel    (y_sel),
        .y_valid  (y_valid),
        .y_ready  (y_ready)
    );

    function automatic logic [3:0] ch(input logic [23:0] v, input int i);
        return v[i*4 +: 4];
    endfunction

    task automatic push(input int s, input logic [3:0] v);
        exp_q.push_back({3'(s), v});
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    // Scoreboard monitor: every transfer (valid and ready at the sample point) pops one expectation
    always @(negedge clk) begin
        if (mon_on && y_valid === 1'b1 && y_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_extra: got sel %0d y %0h with nothing expected", y_sel, y);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({y_sel, y} !== mon_exp) begin
                    errors++;
                    $display("FAIL sb_sample: got sel %0d y %0h expected sel %0d y %0h",
                             y_sel, y, mon_exp[6:4], mon_exp[3:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        mode     = 1'b0;
        sel_in   = '0;
        sel_load = 1'b0;
        dwell    = '0;
        chan_en  = '0;
        d        = '0;
        y_ready  = 1'b1;

        // Reset state
        nxt();
        nxt();
        neg();
        chk("rst_y", y, 0);
        chk("rst_y_sel", y_sel, 0);
        chk("rst_y_valid", y_valid, 0);

        // Manual: loads 0..3, data toggling every 5 cycles, one-register latency on sel
        mon_on  = 1'b1;
        rst_n   = 1'b1;
        mode    = 1'b0;
        chan_en = '1;
        msel    = 0;
        for (int c = 0; c < 20; c++) begin
            d        = (((c / 5) % 2) == 0) ? D_A : D_B;
            sel_load = ((c % 5) == 0);
            sel_in   = 3'(c / 5);
            push(msel, ch(d, msel));
            if (sel_load) msel = c / 5;
            nxt();
        end

        // Manual -> scan, dwell=2, channels 0,1,3 enabled
        d        = D_A;
        mode     = 1'b1;
        dwell    = 8'd2;
        chan_en  = 6'b001011;
        sel_load = 1'b1;
        sel_in   = 3'd0;
        nxt();
        sel_load = 1'b0;
        neg();
        chk("switch_clears_valid", y_valid, 0);
        push(0, 4'h1); push(1, 4'h2); push(3, 4'h4);
        push(0, 4'h1); push(1, 4'h2); push(3, 4'h4);
        for (int i = 1; i <= 18; i++) begin
            nxt();
            neg();
            chk("scan_cadence", y_valid, 32'((i % 3) == 0));
        end

        // dwell=0 with a 5-cycle stall after the first capture
        dwell    = 8'd0;
        sel_load = 1'b1;
        sel_in   = 3'd0;
        push(0, 4'h1);
        nxt();
        sel_load = 1'b0;
        nxt();
        y_ready = 1'b0;
        d       = D_B;
        push(1, 4'hD);
        push(3, 4'hB);
        neg();
        chk("stall_first_valid", y_valid, 1);
        for (int k = 1; k <= 5; k++) begin
            nxt();
            if (k == 5) y_ready = 1'b1;
            neg();
            chk("stall_sel", y_sel, 0);
            chk("stall_y", y, 1);
            chk("stall_valid", y_valid, 1);
        end
        nxt();
        neg();
        chk("stall_resume_sel", y_sel, 1);
        nxt();
        dwell = 8'd3;

        // All channels disabled with a pending sample, then only channel 2
        nxt();
        y_ready = 1'b0;
        nxt();
        nxt();
        nxt();
        push(0, 4'hE);
        neg();
        chk("noch_pending_valid", y_valid, 1);
        chk("noch_pending_sel", y_sel, 0);
        nxt();
        chan_en = '0;
        for (int k = 0; k < 3; k++) begin
            nxt();
            neg();
            chk("noch_hold_valid", y_valid, 1);
            chk("noch_hold_sel", y_sel, 0);
        end
        nxt();
        y_ready = 1'b1;
        neg();
        nxt();
        chan_en = 6'b000100;
        neg();
        chk("noch_accepted", y_valid, 0);
        push(2, 4'hC);
        for (int k = 1; k <= 5; k++) begin
            nxt();
            neg();
            chk("noch_resume_valid", y_valid, 32'(k == 5));
        end
        chk("noch_resume_sel", y_sel, 2);

        // Reset with a sample pending
        nxt();
        nxt();
        nxt();
        y_ready = 1'b0;
        nxt();
        neg();
        chk("pre_reset_valid", y_valid, 1);
        rst_n = 1'b0;
        mode  = 1'b0;
        nxt();
        mon_on = 1'b0;
        neg();
        chk("midscan_rst_y", y, 0);
        chk("midscan_rst_y_sel", y_sel, 0);
        chk("midscan_rst_valid", y_valid, 0);

        // Select range: 5 loads, 7 is ignored
        rst_n    = 1'b1;
        chan_en  = '1;
        d        = D_B;
        y_ready  = 1'b1;
        sel_load = 1'b1;
        sel_in   = 3'd5;
        nxt();
        sel_in = 3'd7;
        nxt();
        sel_load = 1'b0;
        neg();
        chk("load5_sel", y_sel, 5);
        chk("load5_y", y, 9);
        chk("load5_valid", y_valid, 1);
        nxt();
        neg();
        chk("load7_ignored", y_sel, 5);

        chk("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scan_mux.md
# scan_mux

Parametrised, registered N:1 multiplexer: the sequential successor to our 4:1 mux primitive. It selects one of N_CH channels of WIDTH bits, either under direct host control or by autonomously scanning the enabled channels with a programmable dwell time. Scanned samples go to the downstream consumer over a valid/ready handshake. It sits between the sensor/data channel inputs and the single shared processing path.

## Interface
- N_CH, 4, number of input channels (2..64)
- WIDTH, 1, bits per channel
- DWELL_W, 8, width of dwell counter/setting
- SEL_W, $clog2(N_CH), derived; not overridden
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset; one clock domain
- mode  in  1  0 = manual, 1 = scan
- sel_in  in  SEL_W  channel to load into select register
- sel_load  in  1  load sel_in this cycle
- dwell  in  DWELL_W  cycles between scan captures, minus one
- chan_en  in  N_CH  per-channel enable mask
- d  in  N_CH*WIDTH  channel data, channel i at bits [i*WIDTH +: WIDTH]
- y  out  WIDTH  registered output sample
- y_sel  out  SEL_W  channel index that produced y
- y_valid  out  1  y/y_sel hold a valid sample
- y_ready  in  1  consumer accepts sample (scan mode only)

## Operation
- Internal: sel register (SEL_W), cnt (DWELL_W), state ∈ {MANUAL, SCAN, NOCH}.
- Reset (rst_n=0 at edge): y=0, y_sel=0, y_valid=0, sel=0, cnt=0, state=MANUAL. The first post-reset edge moves to the state selected by mode.
- sel_load: sel<=sel_in. If sel_in ≥ N_CH, the load is ignored. In SCAN, a load also sets cnt<=0.
- MANUAL:
  - Every edge: y<=d[sel], y_sel<=sel, y_valid<=chan_en[sel].
  - y_ready is ignored.
- SCAN:
  - Capture is allowed when !y_valid || y_ready.
  - When cnt<dwell: cnt++.
  - When cnt==dwell and capture is allowed:
    - If chan_en[sel]: y<=d[sel], y_sel<=sel, y_valid<=1.
    - Either way: cnt<=0 and sel<=next enabled channel after sel, searching upward and wrapping N_CH-1→0. sel stays put if it is the only enabled channel.
  - When cnt==dwell and capture is blocked: cnt holds and sel holds. y/y_valid are never overwritten while unaccepted.
  - If y_valid && y_ready and no capture occurs on that edge: y_valid<=0.
- NOCH: entered from SCAN when chan_en==0.
  - No captures; cnt holds at 0.
  - The pending sample stays valid until accepted.
  - Return to SCAN once any chan_en bit is set. Resume at the next enabled channel at or after sel, with cnt=0.
- Mode changes:
  - MANUAL→SCAN: y_valid<=0, cnt<=0, scanning starts at current sel.
  - SCAN/NOCH→MANUAL: any unaccepted sample is dropped. Manual behaviour applies from that edge.
- dwell=0 gives a capture every cycle while y_ready=1. A change to dwell takes effect on the next compare.

## Timing
- MANUAL latency: d/sel change before edge k appears on y after edge k. One register stage, no bubbles.
- SCAN: first capture occurs on edge dwell+1 after entering SCAN.
- Steady throughput with y_ready=1 is one sample per dwell+1 cycles.
- y_ready low stalls the scan with zero loss. The capture occurs on the edge where y_ready is sampled high.
- sel_load and capture on the same edge: the load wins. No capture that edge, cnt<=0.
- Reset mid-sample discards the pending y_valid immediately.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Package scan_mux_pkg holds:
  - the state enum (MANUAL, SCAN, NOCH);
  - a mode encoding constant;
  - function next_en(sel, mask), the rotate-and-priority-encode used by both FSM and NOCH exit.
- One sub-module, rr_next_sel: combinational wrap-around next-enabled-channel finder, parametrised by N_CH. Instantiated once.
- FSM, counter and output registers live in scan_mux.

## Test plan
- Manual, N_CH=4, WIDTH=1, all enabled: sel_load 0,1,2,3 while toggling d every 5 cycles -> y equals d[sel] one cycle later; y_sel tracks; y_valid=1 throughout.
- Scan, dwell=2, chan_en=4'b1011, y_ready=1 -> captures every 3 cycles with y_sel sequence 0,1,3,0,1,3; channel 2 never appears.
- Scan, dwell=0, y_ready low 5 cycles after the first capture -> y/y_sel frozen for those 5 cycles. The next capture happens on the edge y_ready returns high. No channel is skipped.
- Scan, chan_en→0 mid-dwell with a pending sample, then chan_en=4'b0100 -> pending sample held until accepted, no new captures, then resume at channel 2 after dwell+1 cycles.
- Reset and mode edges: rst_n=0 mid-scan -> all outputs 0 next edge. sel_in=5 with N_CH=6 loads; sel_in=7 is ignored. Manual→scan clears y_valid on the switch edge.
